coax_buffered_rx: RTL and testbench
===================================

# coax_buffered_rx

Receive-side buffer between the low-level coax word receiver and `control`; the counterpart of `coax_buffered_tx`. It frames incoming 10-bit words into a FIFO and latches receive errors. It presents `active`, `error`, `data` and `empty` to the SPI command logic, which drains words with a one-cycle read strobe.

## Interface

Parameters:
- `DEPTH`, 256: FIFO depth in 10-bit words; power of two, minimum 4.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_active`  in  1  receiver is inside a frame (level).
- `in_data`  in  10  received word, or error code when `in_error` is high.
- `in_strobe`  in  1  one-cycle pulse: `in_data` holds a valid word.
- `in_error`  in  1  one-cycle pulse: receiver detected an error; `in_data` holds its code.
- `read_strobe`  in  1  one-cycle pop request from `control`.
- `active`  out  1  high in RECEIVING state.
- `error`  out  1  high in ERROR state.
- `data`  out  10  FIFO head word, or latched error code when `error` is high.
- `empty`  out  1  FIFO holds no words.
- `full`  out  1  FIFO holds `DEPTH` words.

## Operation

- States: IDLE, RECEIVING, ERROR. Reset state is IDLE.
- `in_active` is registered once. A frame start is the registered 0->1 edge, and a frame end is the registered 1->0 edge.
- IDLE -> RECEIVING on frame start. The FIFO is flushed and the error code is cleared in the same cycle.
- RECEIVING -> IDLE on frame end. Buffered words are kept for draining in IDLE.
- RECEIVING -> ERROR on `in_error`: the error code is latched from `in_data`.
- RECEIVING -> ERROR on overflow (`in_strobe` with `full` and no same-cycle pop): the error code is 10'h001.
- ERROR -> RECEIVING only on frame start, with flush and clear. ERROR is held through frame end.
- Entering ERROR flushes the FIFO.
- Writes are accepted only in RECEIVING. `in_strobe` in IDLE or ERROR is ignored.
- Pops are accepted when not empty and not in ERROR. Otherwise `read_strobe` is ignored.
- Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
  - `empty` means the pointers are equal.
  - `full` means the pointers differ only in the MSB.
- If `in_error` and `in_strobe` occur in the same cycle, the error wins and the word is discarded.
- If frame start and `in_error` occur in the same cycle, the error wins (ERROR state, code latched, FIFO flushed).

## Timing

- Reset values: `active`=0, `error`=0, `data`=10'h000, `empty`=1, `full`=0; FIFO pointers and error code are 0.
- Reset mid-frame returns immediately to IDLE and discards all data. After release, no frame start is seen until `in_active` has been sampled low, then high.
- Write latency: `in_strobe` in cycle N gives `empty`=0 and `data` valid in cycle N+1.
- Pop latency: `read_strobe` in cycle N makes the next word (or `empty`=1) visible in cycle N+1.
  - `data` is registered head-of-FIFO (first-word fall-through); it is never read combinationally from the strobe.
- Simultaneous write and pop:
  - Non-empty FIFO: both happen and the count is unchanged.
  - Full FIFO: both happen and there is no overflow.
  - Empty FIFO: the write happens and the pop is ignored.
- `active` and `error` update one cycle after the registered `in_active` edge, or one cycle after `in_error`/overflow.
- `data` shows the error code from the first cycle `error` is high.

## Test plan

- Reset, then pulse `in_active` high; strobe 10'h3FF and 10'h000; drop `in_active` -> `active` rises then falls. `data`=10'h3FF with `empty`=0; after one `read_strobe`, `data`=10'h000; after a second, `empty`=1.
- DEPTH=8: strobe 8 words -> `full`=1. A 9th `in_strobe` -> `error`=1, `data`=10'h001, `empty`=1, `active`=0. Start a new frame -> `error`=0, `active`=1, `empty`=1.
- Full FIFO: `in_strobe` and `read_strobe` in the same cycle -> no error, `full` stays 1, head advances by one word.
- Mid-frame `in_error` with `in_data`=10'h0A5 in the same cycle as `in_strobe` -> the word is dropped, `error`=1, `data`=10'h0A5. `read_strobe` during ERROR has no effect.
- `read_strobe` on empty FIFO, and `in_strobe` while IDLE -> `empty` stays 1, pointers unchanged.
- Assert `reset_n`=0 asynchronously between clock edges mid-frame with 3 words buffered -> all outputs reach reset values before the next edge.

Source files
------------

// File: rtl/coax_buffered_rx.sv
// rtl/coax_buffered_rx.sv - receive-side frame buffer between the coax word receiver and control
//
// Frames incoming 10-bit words into a FIFO and latches receive errors.
// Ports:
//   clk, reset_n   system clock (rising edge), asynchronous active-low reset
//   in_active      receiver is inside a frame (level)
//   in_data        received word, or error code while in_error is high
//   in_strobe      one-cycle pulse: in_data holds a valid word
//   in_error       one-cycle pulse: receiver error, in_data holds its code
//   read_strobe    one-cycle pop request from control
//   active, error  RECEIVING / ERROR state indicators
//   data           registered FIFO head word, or latched error code in ERROR
//   empty, full    FIFO occupancy flags
module coax_buffered_rx #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_active,
  input  logic [9:0] in_data,
  input  logic       in_strobe,
  input  logic       in_error,
  input  logic       read_strobe,
  output logic       active,
  output logic       error,
  output logic [9:0] data,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RECEIVING = 2'd1,
    S_ERROR     = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        active_q;
  logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic [9:0]  code, code_next, data_next;
  logic        wr_en, rd_adv, flush, pop_ok;
  logic        frame_start, frame_end;
  logic [9:0]  mem [DEPTH];

  // Edges are taken between the live input and its registered copy. active_q
  // resets high so a frame already in progress at reset release is not seen
  // as a start until in_active has been low once.
  assign frame_start = in_active & ~active_q;
  assign frame_end   = ~in_active & active_q;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign pop_ok = read_strobe & ~empty & (state != S_ERROR);

  assign active = (state == S_RECEIVING);
  assign error  = (state == S_ERROR);

  always_comb begin
    state_next = state;
    code_next  = code;
    wr_en      = 1'b0;
    rd_adv     = 1'b0;
    flush      = 1'b0;
    case (state)
      S_IDLE, S_ERROR: begin
        if (frame_start) begin
          flush = 1'b1;
          // An error in the same cycle as the frame start takes precedence.
          if (in_error) begin
            state_next = S_ERROR;
            code_next  = in_data;
          end else begin
            state_next = S_RECEIVING;
            code_next  = 10'h000;
          end
        end else if (state == S_IDLE) begin
          rd_adv = pop_ok;
        end
      end
      S_RECEIVING: begin
        if (in_error) begin
          state_next = S_ERROR;
          code_next  = in_data;
          flush      = 1'b1;
        end else if (in_strobe && full && !pop_ok) begin
          state_next = S_ERROR;
          code_next  = 10'h001;
          flush      = 1'b1;
        end else begin
          wr_en  = in_strobe;
          rd_adv = pop_ok;
          if (frame_end) begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    wr_next = flush ? '0 : wr_ptr + {{AW{1'b0}}, wr_en};
    rd_next = flush ? '0 : rd_ptr + {{AW{1'b0}}, rd_adv};

    // Head register: when the next head is the slot being written this cycle,
    // bypass the memory and take the incoming word directly.
    if (state_next == S_ERROR) begin
      data_next = code_next;
    end else if (wr_en && (rd_next == wr_ptr)) begin
      data_next = in_data;
    end else begin
      data_next = mem[rd_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      active_q <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      code     <= 10'h000;
      data     <= 10'h000;
    end else begin
      state    <= state_next;
      active_q <= in_active;
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      code     <= code_next;
      data     <= data_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_coax_buffered_rx.sv
// tb/tb_coax_buffered_rx.sv - self-checking bench for coax_buffered_rx
module tb_coax_buffered_rx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_active;
  logic [9:0] in_data;
  logic       in_strobe;
  logic       in_error;
  logic       read_strobe;
  logic       active;
  logic       error;
  logic [9:0] data;
  logic       empty;
  logic       full;

  int checks = 0;
  int fails  = 0;

  // Reference model: frame state (0 idle, 1 receiving, 2 error), word queue,
  // latched code and last sampled in_active.
  int         m_state;
  logic [9:0] q[$];
  logic [9:0] m_code;
  logic       m_prev;

  coax_buffered_rx #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_active  (in_active),
    .in_data    (in_data),
    .in_strobe  (in_strobe),
    .in_error   (in_error),
    .read_strobe(read_strobe),
    .active     (active),
    .error      (error),
    .data       (data),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0;
    q.delete();
    m_code = 10'h000;
    m_prev = 1'b1;
  endtask

  task automatic model_update();
    bit fs, fe, fl, pp;
    fs = in_active && !m_prev;
    fe = !in_active && m_prev;
    fl = (q.size() == DEPTH);
    pp = read_strobe && (q.size() != 0) && (m_state != 2);
    if (m_state != 1) begin
      if (fs) begin
        q.delete();
        if (in_error) begin
          m_state = 2;
          m_code  = in_data;
        end else begin
          m_state = 1;
          m_code  = 10'h000;
        end
      end else if (m_state == 0 && pp) begin
        void'(q.pop_front());
      end
    end else begin
      if (in_error) begin
        m_state = 2;
        m_code  = in_data;
        q.delete();
      end else if (in_strobe && fl && !pp) begin
        m_state = 2;
        m_code  = 10'h001;
        q.delete();
      end else begin
        if (pp) void'(q.pop_front());
        if (in_strobe) q.push_back(in_data);
        if (fe) m_state = 0;
      end
    end
    m_prev = in_active;
  endtask

  // One clock: advance the model with the current inputs, clock the DUT,
  // sample 1ns after the edge, then clear the pulse inputs.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    in_strobe   = 1'b0;
    in_error    = 1'b0;
    read_strobe = 1'b0;
  endtask

  task automatic push_word(input logic [9:0] w);
    in_strobe = 1'b1;
    in_data   = w;
    step();
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    in_active   = 1'b0;
    in_data     = 10'h000;
    in_strobe   = 1'b0;
    in_error    = 1'b0;
    read_strobe = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    m_prev = 1'b0;
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b expected 0", active); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (data !== 10'h000) begin fails++; $display("FAIL reset_data: got %h expected 000", data); end
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
  endtask

  task automatic test_basic_frame();
    in_active = 1'b1;
    step();
    checks++; if (active !== 1'b1) begin fails++; $display("FAIL basic_active_rise: got %b expected 1", active); end
    push_word(10'h3FF);
    checks++; if (empty !== 1'b0 || data !== 10'h3FF) begin fails++; $display("FAIL basic_first_word: got empty=%b data=%h expected empty=0 data=3ff", empty, data); end
    push_word(10'h000);
    in_active = 1'b0;
    step();
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL basic_active_fall: got %b expected 0", active); end
    checks++; if (data !== 10'h3FF || empty !== 1'b0) begin fails++; $display("FAIL basic_idle_head: got empty=%b data=%h expected empty=0 data=3ff", empty, data); end
    read_strobe = 1'b1;
    step();
    checks++; if (data !== 10'h000 || empty !== 1'b0) begin fails++; $display("FAIL basic_pop1: got empty=%b data=%h expected empty=0 data=000", empty, data); end
    read_strobe = 1'b1;
    step();
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL basic_pop2: got empty=%b expected 1", empty); end
  endtask

  task automatic test_overflow();
    logic [9:0] first;
    in_active = 1'b1;
    step();
    first = 10'($urandom);
    push_word(first);
    for (int i = 1; i < DEPTH; i++) push_word(10'($urandom));
    checks++; if (full !== 1'b1 || data !== first) begin fails++; $display("FAIL ovf_full: got full=%b data=%h expected full=1 data=%h", full, data, first); end
    push_word(10'($urandom));
    checks++; if (error !== 1'b1 || data !== 10'h001 || empty !== 1'b1 || active !== 1'b0)
      begin fails++; $display("FAIL ovf_error: got error=%b data=%h empty=%b active=%b expected 1 001 1 0", error, data, empty, active); end
    in_active = 1'b0;
    step();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL ovf_hold_through_end: got error=%b expected 1", error); end
    in_active = 1'b1;
    step();
    checks++; if (error !== 1'b0 || active !== 1'b1 || empty !== 1'b1)
      begin fails++; $display("FAIL ovf_restart: got error=%b active=%b empty=%b expected 0 1 1", error, active, empty); end
  endtask

  task automatic test_full_simultaneous();
    logic [9:0] w [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = 10'($urandom);
      push_word(w[i]);
    end
    in_strobe   = 1'b1;
    in_data     = 10'h155;
    read_strobe = 1'b1;
    step();
    checks++; if (error !== 1'b0 || full !== 1'b1 || data !== w[1])
      begin fails++; $display("FAIL full_rw: got error=%b full=%b data=%h expected 0 1 %h", error, full, data, w[1]); end
    in_active = 1'b0;
    step();
  endtask

  task automatic test_error_with_strobe();
    in_active = 1'b1;
    step();
    push_word(10'h011);
    push_word(10'h022);
    in_error  = 1'b1;
    in_strobe = 1'b1;
    in_data   = 10'h0A5;
    step();
    checks++; if (error !== 1'b1 || data !== 10'h0A5 || empty !== 1'b1)
      begin fails++; $display("FAIL err_strobe: got error=%b data=%h empty=%b expected 1 0a5 1", error, data, empty); end
    read_strobe = 1'b1;
    step();
    checks++; if (error !== 1'b1 || data !== 10'h0A5 || empty !== 1'b1)
      begin fails++; $display("FAIL err_read_ignored: got error=%b data=%h empty=%b expected 1 0a5 1", error, data, empty); end
    in_active = 1'b0;
    step();
  endtask

  task automatic test_ignored();
    logic [9:0] w;
    in_active = 1'b1;
    step();
    in_active = 1'b0;
    step();
    read_strobe = 1'b1;
    step();
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL read_on_empty: got empty=%b expected 1", empty); end
    push_word(10'h2AA);
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL strobe_in_idle: got empty=%b full=%b expected 1 0", empty, full); end
    in_active = 1'b1;
    step();
    w = 10'($urandom);
    push_word(w);
    checks++; if (empty !== 1'b0 || data !== w) begin fails++; $display("FAIL after_ignored_write: got empty=%b data=%h expected 0 %h", empty, data, w); end
    read_strobe = 1'b1;
    step();
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL after_ignored_pop: got empty=%b expected 1", empty); end
    in_active = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    in_active = 1'b1;
    step();
    for (int i = 0; i < 3; i++) push_word(10'($urandom));
    checks++; if (empty !== 1'b0 || active !== 1'b1) begin fails++; $display("FAIL areset_pre: got empty=%b active=%b expected 0 1", empty, active); end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if ({active, error, data, empty, full} !== {1'b0, 1'b0, 10'h000, 1'b1, 1'b0})
      begin fails++; $display("FAIL areset_async: got active=%b error=%b data=%h empty=%b full=%b expected 0 0 000 1 0", active, error, data, empty, full); end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step();
    checks++; if (active !== 1'b0) begin fails++; $display("FAIL areset_no_start_while_high: got %b expected 0", active); end
    in_active = 1'b0;
    step();
    in_active = 1'b1;
    step();
    checks++; if (active !== 1'b1 || empty !== 1'b1) begin fails++; $display("FAIL areset_restart: got active=%b empty=%b expected 1 1", active, empty); end
    in_active = 1'b0;
    step();
  endtask

  task automatic test_random();
    int rd_pct;
    logic [3:0] exp_flags;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) rd_pct = $urandom_range(10, 90);
      if ($urandom_range(0, 24) == 0) in_active = ~in_active;
      in_strobe   = ($urandom_range(0, 99) < 55);
      in_data     = 10'($urandom);
      in_error    = ($urandom_range(0, 99) == 0);
      read_strobe = ($urandom_range(0, 99) < rd_pct);
      step();
      exp_flags = {m_state == 1, m_state == 2, q.size() == 0, q.size() == DEPTH};
      checks++; if ({active, error, empty, full} !== exp_flags)
        begin fails++; $display("FAIL rand_flags cycle %0d: got %b expected %b", n, {active, error, empty, full}, exp_flags); end
      if (m_state == 2) begin
        checks++; if (data !== m_code) begin fails++; $display("FAIL rand_code cycle %0d: got %h expected %h", n, data, m_code); end
      end else if (q.size() != 0) begin
        checks++; if (data !== q[0]) begin fails++; $display("FAIL rand_head cycle %0d: got %h expected %h", n, data, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_full_simultaneous();
    test_error_with_strobe();
    test_ignored();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
